// File: rtl/arith_pkg.sv
// Shared definitions for the multi-cycle arithmetic blocks.
//   state_t    : FSM states of the chunked subtractor (IDLE, RUN, DONE)
//   WIDTH_DEF  : default operand/result width
//   num_chunks : number of CHUNK-wide slices in a WIDTH-wide word
//   cnt_width  : bits needed for the chunk counter (never less than 1)
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_DEF = 32;

    function automatic int num_chunks(input int width, input int chunk);
        return width / chunk;
    endfunction

    function automatic int cnt_width(input int width, input int chunk);
        int w;
        w = $clog2(width / chunk);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/serial_sub32_if.sv
// Handshake bundle for the serial subtractor.
//   in_valid/in_ready   : operand handshake (producer -> subtractor)
//   a, b                : minuend and subtrahend
//   out_valid/out_ready : result handshake (subtractor -> consumer)
//   diff                : a - b modulo 2^WIDTH
//   borrow_out          : unsigned a < b
//   overflow            : signed overflow of a - b
//   zero                : diff == 0
// slave is the subtractor's view, master is the surrounding datapath's view.
interface serial_sub32_if
    import arith_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             overflow;
    logic             zero;

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, borrow_out, overflow, zero
    );

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, borrow_out, overflow, zero
    );

endinterface

// File: rtl/sub_chunk.sv
// Combinational CHUNK-bit subtract cell: d_c = a_c + ~b_c + cin.
//   a_c  : minuend slice
//   b_c  : subtrahend slice (inverted internally)
//   cin  : carry in (1 for the least significant slice of a subtraction)
//   d_c  : difference slice
//   cout : carry out; its inverse is the borrow of this slice
module sub_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a_c,
    input  logic [CHUNK-1:0] b_c,
    input  logic             cin,
    output logic [CHUNK-1:0] d_c,
    output logic             cout
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        logic bn;
        assign bn       = ~b_c[i];
        assign d_c[i]   = a_c[i] ^ bn ^ c[i];
        assign c[i+1]   = (a_c[i] & bn) | (c[i] & (a_c[i] ^ bn));
    end

    assign cout = c[CHUNK];

endmodule

// File: rtl/serial_sub32.sv
// Multi-cycle subtractor: diff = a - b, CHUNK bits per clock, LSB slice first.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : serial_sub32_if.slave (operand and result valid/ready handshakes,
//           diff, borrow_out, overflow, zero)
// Operands are latched on the accept edge; one sub_chunk cell is reused for
// every slice, with the carry held in a register between slices. Result and
// flags are only driven while the result is valid so no partial value leaks.
module serial_sub32
    import arith_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CHUNK = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_sub32_if.slave bus
);

    localparam int            NCH  = num_chunks(WIDTH, CHUNK);
    localparam int            CW   = cnt_width(WIDTH, CHUNK);
    localparam logic [CW-1:0] LAST = CW'(NCH - 1);

    state_t           state;
    state_t           state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] d_r;
    logic [WIDTH-1:0] d_nx;
    logic             carry;
    logic             borrow_r;
    logic             ovf_r;
    logic             zero_r;

    logic [31:0]      base;
    logic [CHUNK-1:0] a_c;
    logic [CHUNK-1:0] b_c;
    logic [CHUNK-1:0] d_c;
    logic             cout;
    logic             accept;
    logic             last;

    assign accept = (state == IDLE) && bus.in_valid;
    assign last   = (state == RUN) && (cnt == LAST);

    // Select the current slice by shifting rather than a variable part-select,
    // which keeps CHUNK == WIDTH (no shift at all) legal.
    assign base = 32'(cnt) * 32'(CHUNK);
    assign a_c  = CHUNK'(a_r >> base);
    assign b_c  = CHUNK'(b_r >> base);

    sub_chunk #(
        .CHUNK(CHUNK)
    ) u_sub (
        .a_c  (a_c),
        .b_c  (b_c),
        .cin  (carry),
        .d_c  (d_c),
        .cout (cout)
    );

    // d_r is cleared on accept, so OR-ing the new slice into place is exact.
    // Flags on the last slice are computed from d_nx, the complete result.
    assign d_nx = d_r | (WIDTH'(d_c) << base);

    // ---- FSM state register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // ---- FSM next state and handshake/result outputs ----
    always_comb begin
        state_nx       = state;
        bus.in_ready   = 1'b0;
        bus.out_valid  = 1'b0;
        bus.diff       = '0;
        bus.borrow_out = 1'b0;
        bus.overflow   = 1'b0;
        bus.zero       = 1'b0;
        unique case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                bus.out_valid  = 1'b1;
                bus.diff       = d_r;
                bus.borrow_out = borrow_r;
                bus.overflow   = ovf_r;
                bus.zero       = zero_r;
                if (bus.out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // ---- Operand latch and slice-serial datapath ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r      <= '0;
            b_r      <= '0;
            d_r      <= '0;
            cnt      <= '0;
            carry    <= 1'b0;
            borrow_r <= 1'b0;
            ovf_r    <= 1'b0;
            zero_r   <= 1'b0;
        end else if (accept) begin
            a_r   <= bus.a;
            b_r   <= bus.b;
            d_r   <= '0;
            cnt   <= '0;
            carry <= 1'b1;
        end else if (state == RUN) begin
            d_r   <= d_nx;
            carry <= cout;
            cnt   <= cnt + CW'(1);
            if (last) begin
                borrow_r <= ~cout;
                ovf_r    <= (a_r[WIDTH-1] != b_r[WIDTH-1]) && (d_nx[WIDTH-1] != a_r[WIDTH-1]);
                zero_r   <= (d_nx == '0);
            end
        end
    end

endmodule

// File: doc/serial_sub32.md
Name: serial_sub32

Overview:
- Multi-cycle 32-bit subtractor computing DIFF = A - B, with borrow, signed-overflow and zero flags.
- It is the inverse-direction companion to the combinational ripple-carry adder: subtraction instead of addition, processed CHUNK bits per clock to keep the carry chain short.
- Valid/ready handshakes on both input and output, so it can sit between pipeline stages in the arithmetic datapath.

Parameters:
- WIDTH, 32, operand and result width; must be a multiple of CHUNK.
- CHUNK, 8, bits subtracted per clock; legal values 1, 2, 4, 8, 16, 32.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands A and B are valid.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  consumer accepts the result.
- diff  output  WIDTH  A - B modulo 2^WIDTH.
- borrow_out  output  1  1 when unsigned A < B.
- overflow  output  1  signed overflow of A - B.
- zero  output  1  diff == 0.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; all outputs are 0 except in_ready.
  - in_ready = 1 once the block is in IDLE after reset.
  - Internal operand, result and carry registers clear to 0.
- Arithmetic: two's-complement subtraction, A + ~B + 1.
  - The carry register is initialised to 1 on accept.
  - Each RUN cycle processes chunk k (bits k*CHUNK+CHUNK-1 .. k*CHUNK, LSB chunk first) and writes the chunk sum into the diff register.
  - Carry-out of each chunk feeds the next chunk.
  - borrow_out = NOT final carry.
  - overflow = (a[MSB] != b[MSB]) AND (diff[MSB] != a[MSB]).
  - zero = (diff == 0), evaluated on the final diff.
- State machine:
  - IDLE: in_ready = 1. On in_valid & in_ready, latch a and b, chunk counter = 0, carry = 1, go to RUN.
  - RUN: in_ready = 0. Process one chunk per cycle and increment the counter. When counter == WIDTH/CHUNK-1, process the last chunk, register the flags and go to DONE.
  - DONE: out_valid = 1; diff and flags stay stable. On out_ready, go to IDLE next cycle.
- Latency:
  - Accept edge at cycle N; RUN occupies edges N+1 .. N+WIDTH/CHUNK.
  - out_valid is high from after edge N+WIDTH/CHUNK, i.e. 4 cycles for the defaults.
  - Throughput is one operation per WIDTH/CHUNK + 2 cycles, minimum.
- Backpressure: with out_ready low in DONE, hold every output indefinitely. in_ready stays 0, so no new operation can be accepted.
- in_valid outside IDLE is ignored; the operand latch is not disturbed.
- out_ready outside DONE is ignored.
- Reset mid-RUN or mid-DONE aborts the operation immediately: out_valid = 0, state = IDLE, no partial result is visible.
- Changing a or b after the accept edge has no effect on the result.
- CHUNK == WIDTH is legal: RUN lasts exactly 1 cycle.

Decomposition:
- Shared package arith_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the WIDTH default constant;
  - a function computing WIDTH/CHUNK and the counter width, $clog2 with a minimum of 1.
- One sub-module, sub_chunk:
  - combinational CHUNK-bit subtract cell (inputs a_c, b_c, cin; outputs d_c, cout);
  - built from inverted-B full-adder cells;
  - instantiated once and time-multiplexed by the FSM.

Test Plan:
- a=5, b=3 -> after 4 cycles: diff=0x00000002, borrow_out=0, overflow=0, zero=0.
- a=3, b=5 -> diff=0xFFFFFFFE, borrow_out=1, overflow=0, zero=0.
- a=0x80000000, b=1 -> diff=0x7FFFFFFF, borrow_out=0, overflow=1; then a=0x12345678, b=0x12345678 -> diff=0, zero=1, borrow_out=0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE, toggling in_valid with new operands -> outputs stable, in_ready=0, new operands not accepted. Release out_ready -> IDLE next cycle, then the next operand is accepted.
- Reset mid-op: drop rst_n during the 2nd RUN cycle -> out_valid=0, in_ready=1 after release. A following a=0, b=1 gives diff=0xFFFFFFFF, borrow_out=1.
- Random back-to-back regression (10k vectors, CHUNK=1, 8 and 32) vs a reference model of a-b, with random out_ready stalls -> exact diff and flag match, latency = WIDTH/CHUNK cycles.
